// File: rtl/mult_div_unit_seq.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one result bit per cycle, with start/ready/done handshake and synchronous kill.
module mult_div_unit_seq #(
   parameter int parallelism = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   kill,
   input  logic [2:0]             opCode,
   input  logic [parallelism-1:0] lOp,
   input  logic [parallelism-1:0] rOp,
   output logic                   ready,
   output logic                   done,
   output logic [parallelism-1:0] result,
   output logic                   divByZero
);

   // state | meaning
   // IDLE  | ready for a new op
   // PREP  | magnitudes, result signs, special-case detection
   // CALC  | one multiply/divide step per cycle, cnt_q counts down to 0
   // FIX   | sign correction, result select, done pulse
   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

   localparam int P  = parallelism;
   localparam int CW = $clog2(P);
   localparam logic [P-1:0] MIN_NEG = {1'b1, {(P-1){1'b0}}};

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      op_q;
   logic [P-1:0]    l_q, r_q, b_q;
   logic [2*P-1:0]  acc_q;
   logic [P:0]      rem_q;
   logic            neg_q, negr_q, spec_q, spec_dbz_q;
   logic            ready_q, done_q, dbz_q;
   logic [P-1:0]    result_q;

   logic            l_sgn, r_sgn, s_l, s_r, div_zero, ovf;
   logic [P-1:0]    mag_l, mag_r, quo, rmd, fix_res;
   logic [P:0]      add_sum, shifted;
   logic [P+1:0]    trial;
   logic [2*P-1:0]  mul_acc_d, div_acc_d, prod;
   logic [P:0]      rem_d;

   always_comb begin
      l_sgn    = op_q[2] ? ~op_q[0] : (op_q != 3'b011);
      r_sgn    = op_q[2] ? ~op_q[0] : ~op_q[1];
      s_l      = l_sgn & l_q[P-1];
      s_r      = r_sgn & r_q[P-1];
      mag_l    = s_l ? -l_q : l_q;
      mag_r    = s_r ? -r_q : r_q;
      div_zero = op_q[2] && (r_q == '0);
      ovf      = op_q[2] && !op_q[0] && (l_q == MIN_NEG) && (r_q == '1);

      // multiply: add multiplicand when the current multiplier bit is set, then shift right
      add_sum   = {1'b0, acc_q[2*P-1:P]} + {1'b0, (acc_q[0] ? b_q : {P{1'b0}})};
      mul_acc_d = {add_sum, acc_q[P-1:1]};

      // restoring divide: the dividend shifts out of acc_q's low half as quotient bits shift in
      shifted   = {rem_q[P-1:0], acc_q[P-1]};
      trial     = {1'b0, shifted} - {2'b00, b_q};
      rem_d     = trial[P+1] ? shifted : trial[P:0];
      div_acc_d = {acc_q[2*P-1:P], acc_q[P-2:0], ~trial[P+1]};

      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[P-1:0] : acc_q[P-1:0];
      rmd  = negr_q ? -rem_q[P-1:0] : rem_q[P-1:0];

      if (spec_q)
         fix_res = acc_q[P-1:0];
      else if (!op_q[2])
         fix_res = (op_q == 3'b000) ? prod[P-1:0] : prod[2*P-1:P];
      else
         fix_res = op_q[1] ? rmd : quo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         l_q        <= '0;
         r_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         neg_q      <= 1'b0;
         negr_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_dbz_q <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (kill && state_q != IDLE) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !kill) begin
                     op_q    <= opCode;
                     l_q     <= lOp;
                     r_q     <= rOp;
                     ready_q <= 1'b0;
                     state_q <= PREP;
                  end
               end
               PREP: begin
                  neg_q      <= s_l ^ s_r;
                  negr_q     <= s_l;
                  rem_q      <= '0;
                  spec_dbz_q <= div_zero;
                  if (div_zero) begin
                     spec_q  <= 1'b1;
                     acc_q   <= {{P{1'b0}}, (op_q[1] ? l_q : {P{1'b1}})};
                     state_q <= FIX;
                  end else if (ovf) begin
                     spec_q  <= 1'b1;
                     acc_q   <= {{P{1'b0}}, (op_q[1] ? {P{1'b0}} : l_q)};
                     state_q <= FIX;
                  end else begin
                     spec_q  <= 1'b0;
                     cnt_q   <= CW'(P-1);
                     b_q     <= op_q[2] ? mag_r : mag_l;
                     acc_q   <= {{P{1'b0}}, (op_q[2] ? mag_l : mag_r)};
                     state_q <= CALC;
                  end
               end
               CALC: begin
                  acc_q <= op_q[2] ? div_acc_d : mul_acc_d;
                  if (op_q[2])
                     rem_q <= rem_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0)
                     state_q <= FIX;
               end
               FIX: begin
                  result_q <= fix_res;
                  dbz_q    <= spec_dbz_q;
                  done_q   <= 1'b1;
                  ready_q  <= 1'b1;
                  state_q  <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign result    = result_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit_seq.sv
// Bench for mult_div_unit_seq: vector table, random ops against a reference model,
// and hand-written handshake/kill/reset/width sequences; expected results via a queue.
module tb_mult_div_unit_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, start8, kill;
   logic [2:0]  op;
   logic [31:0] l, r;
   logic [7:0]  l8, r8;
   logic        ready, done, dbz, ready8, done8, dbz8;
   logic [31:0] result;
   logic [7:0]  result8;

   mult_div_unit_seq #(.parallelism(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .opCode(op),
      .lOp(l), .rOp(r), .ready(ready), .done(done), .result(result), .divByZero(dbz));

   mult_div_unit_seq #(.parallelism(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .kill(kill), .opCode(op),
      .lOp(l8), .rOp(r8), .ready(ready8), .done(done8), .result(result8), .divByZero(dbz8));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        dbz;
   } exp_t;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dbz;
      int          lat;
   } vec_t;

   exp_t        scb[$];
   vec_t        vq[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] last_res;
   logic        last_dbz;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
      longint          sa, sbv;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa  = $signed(a);
      sbv = $signed(b);
      ua  = a;
      ub  = b;
      p   = '0;
      case (o)
         3'd0: p = sa * sbv;
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sbv;
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = ua / ub;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sbv;
         end
         default: begin
            if (b == 32'd0) return a;
            p = ua % ub;
         end
      endcase
      return p[31:0];
   endfunction

   task automatic run_op(bit w8, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                         logic [31:0] er, logic edbz, int elat, string name, bit poke);
      int   n;
      bit   seen, busy_ok;
      exp_t e;
      @(negedge clk);
      op = o;
      if (w8) begin l8 = a[7:0]; r8 = b[7:0]; start8 = 1'b1; end
      else    begin l  = a;      r  = b;      start  = 1'b1; end
      @(posedge clk);
      e.res = er;
      e.dbz = edbz;
      scb.push_back(e);
      #1;
      start  = 1'b0;
      start8 = 1'b0;
      op = 3'($urandom);
      l  = $urandom;
      r  = $urandom;
      l8 = 8'($urandom);
      r8 = 8'($urandom);
      if (poke) begin
         fork
            begin
               repeat (5) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         join_none
      end
      n = 0; seen = 0; busy_ok = 1;
      while (n < 200 && !seen) begin
         @(posedge clk);
         n++;
         #1;
         if (w8 ? done8 : done) seen = 1;
         else if (w8 ? ready8 : ready) busy_ok = 0;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s timeout: no done after %0d edges, want %0d", name, n, elat);
         if (scb.size() > 0) void'(scb.pop_front());
      end else begin
         chk({name, " latency"}, 64'(n), 64'(elat));
         chk({name, " ready_in_done"}, 64'(w8 ? ready8 : ready), 64'd1);
         chk({name, " busy_ready"}, 64'(busy_ok), 64'd1);
         if (scb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: done with empty scoreboard", name);
         end else begin
            e = scb.pop_front();
            chk({name, " result"}, w8 ? {56'd0, result8} : {32'd0, result}, {32'd0, e.res});
            chk({name, " divByZero"}, 64'(w8 ? dbz8 : dbz), 64'(e.dbz));
            if (!w8) begin last_res = e.res; last_dbz = e.dbz; end
         end
      end
   endtask

   task automatic no_done(int n, string name);
      bit any = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (done) any = 1;
      end
      chk(name, 64'(any), 64'd0);
   endtask

   initial begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          lat;
      start = 0; start8 = 0; kill = 0; op = 0; l = 0; r = 0; l8 = 0; r8 = 0;
      last_res = 0; last_dbz = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready", 64'(ready), 64'd1);
      chk("rst done", 64'(done), 64'd0);
      chk("rst result", 64'(result), 64'd0);
      chk("rst divByZero", 64'(dbz), 64'd0);
      chk("rst ready8", 64'(ready8), 64'd1);
      @(negedge clk) rst_n = 1'b1;

      vq.push_back('{"mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34});
      vq.push_back('{"mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34});
      vq.push_back('{"mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34});
      vq.push_back('{"mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34});
      vq.push_back('{"mul_low",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 34});
      vq.push_back('{"div",      3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 34});
      vq.push_back('{"rem",      3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 34});
      vq.push_back('{"divu",     3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 1'b0, 34});
      vq.push_back('{"remu",     3'd7, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 1'b0, 34});
      vq.push_back('{"div0",     3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 2});
      vq.push_back('{"rem0",     3'd6, 32'd5,        32'd0,        32'd5,         1'b1, 2});
      vq.push_back('{"divu0",    3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 2});
      vq.push_back('{"remu0",    3'd7, 32'd5,        32'd0,        32'd5,         1'b1, 2});
      vq.push_back('{"div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2});
      vq.push_back('{"rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 2});
      vq.push_back('{"divu_b2b", 3'd5, 32'd100,      32'd7,        32'd14,        1'b0, 34});
      vq.push_back('{"remu_b2b", 3'd7, 32'd100,      32'd7,        32'd2,         1'b0, 34});

      // consecutive run_op calls start in the done cycle of the previous op
      for (int i = 0; i < vq.size(); i++)
         run_op(0, vq[i].op, vq[i].a, vq[i].b, vq[i].res, vq[i].dbz, vq[i].lat, vq[i].name, 0);

      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         lat = ((o[2] && b == 0) || (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
         run_op(0, o, a, b, model(o, a, b), o[2] && (b == 0), lat, "rand", 0);
      end

      run_op(0, 3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 34, "busy_start", 1);
      no_done(40, "busy_no_second_done");

      // kill after ten CALC cycles
      @(negedge clk);
      op = 3'd0; l = 32'd9; r = 32'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk) kill = 1'b1;
      @(posedge clk);
      #1;
      chk("kill ready", 64'(ready), 64'd1);
      chk("kill done", 64'(done), 64'd0);
      @(negedge clk) kill = 1'b0;
      no_done(40, "kill_no_done");
      chk("kill result_held", 64'(result), 64'(last_res));
      chk("kill dbz_held", 64'(dbz), 64'(last_dbz));

      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = 3'd0; l = 32'd2; r = 32'd2;
      @(posedge clk);
      #1;
      chk("kill_start ready", 64'(ready), 64'd1);
      @(negedge clk) begin start = 1'b0; kill = 1'b0; end
      no_done(40, "kill_start_no_done");

      run_op(0, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, "pre_reset_div0", 0);
      @(negedge clk);
      op = 3'd1; l = 32'h1234_5678; r = 32'h9ABC_DEF0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst ready", 64'(ready), 64'd1);
      chk("midrst done", 64'(done), 64'd0);
      chk("midrst result", 64'(result), 64'd0);
      chk("midrst divByZero", 64'(dbz), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      no_done(40, "midrst_no_done");

      run_op(0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0,
             model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0, 34, "post_reset_mulhu", 0);
      run_op(0, 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 34, "post_reset_div", 0);

      run_op(1, 3'd1, 32'h80, 32'h7F, 32'hC0, 1'b0, 10, "w8_mulh", 0);
      run_op(1, 3'd4, 32'h80, 32'hFF, 32'h80, 1'b0, 2,  "w8_div_ovf", 0);
      run_op(1, 3'd5, 32'd200, 32'd7, 32'd28, 1'b0, 10, "w8_divu", 0);
      run_op(1, 3'd6, 32'hF9, 32'd0, 32'hF9, 1'b1, 2, "w8_rem0", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/mult_div_unit_seq.md
Name: mult_div_unit_seq

Overview:
- Iterative multiply/divide unit for the integer core.
- Implements the 8 M-extension ops with one bit processed per cycle: radix-2 shift-add multiply and restoring divide.
- Successor to the combinational sign-correction datapath. Adds width parametrisation, a start/ready/done handshake, abort, and divide-by-zero/overflow handling.
- Sits beside the ALU. The pipeline stalls on ready=0.

Parameters:
- parallelism, 32: operand/result width in bits. Legal values are 4 and up.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- kill  in  1  synchronous abort of the in-flight op
- opCode  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- lOp  in  parallelism  multiplicand/dividend
- rOp  in  parallelism  multiplier/divisor
- ready  out  1  unit idle, can accept start
- done  out  1  one-cycle pulse: result valid
- result  out  parallelism  registered result, held until next done
- divByZero  out  1  registered with result: 1 when the op was DIV/DIVU/REM/REMU with rOp=0

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, done=0, result=0, divByZero=0, counter=0. Reset mid-operation discards the op with no done.
- Operand capture: opCode, lOp and rOp are registered on the start edge (E0). Inputs may change afterwards.
- Signedness per opCode:
  - lOp signed for MUL, MULH, MULHSU, DIV, REM.
  - rOp signed for MUL, MULH, DIV, REM.
  - All others unsigned.
  - Operands are extended to parallelism+1 bits with sign or zero accordingly.
- States:
  - IDLE: ready=1. On start, go to PREP.
  - PREP: take magnitudes and record the result sign.
    - Multiply: result sign = sL xor sR.
    - Quotient sign = sL xor sR; remainder sign = sL.
    - Detect special cases. If one is found, go to FIX with a preloaded result; otherwise go to CALC.
  - CALC: exactly parallelism cycles, counter from parallelism-1 down to 0, then go to FIX.
    - Multiply: 2*parallelism-bit accumulator, conditional add and shift right.
    - Divide: restoring shift-subtract; partial remainder parallelism+1 bits.
  - FIX: conditionally negate (two's complement) and select the output.
    - MUL: low half. MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient. REM/REMU: remainder.
    - Register result and divByZero, pulse done, go to IDLE.
- Latency: done=1 in the cycle after edge E0+parallelism+2, i.e. 34 edges for parallelism=32. Special cases take 2 edges.
- ready: 0 from E0 until the done cycle. ready=1 during the done cycle, so start in that cycle is accepted (back-to-back ops).
- start while ready=0: ignored, no queuing.
- kill=1 in any non-IDLE state: next state IDLE, no done, result and divByZero unchanged.
  - kill in IDLE: no effect.
  - kill and start in the same IDLE cycle: kill wins, start is dropped.
- Special cases, decided in PREP:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = lOp; divByZero=1.
  - Signed overflow, lOp = most-negative with rOp = -1 on DIV/REM: quotient = lOp, remainder = 0, divByZero=0.
- Multiply never flags. divByZero=0 for every multiply op.
- MUL low half is identical for all signedness combinations.

Test Plan:
- Multiply, parallelism=32:
  - MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 edges after start; ready=0 throughout.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU same operands -> 1.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF. Each has divByZero=1 and done 2 edges after start.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; divByZero=0; 2-edge latency.
- Handshake:
  - Start during busy is ignored and the first result is unchanged.
  - Start in the done cycle is accepted: the second done comes 34 edges later.
  - Inputs changed after E0 have no effect.
- Abort and reset:
  - kill at CALC cycle 10 -> no done, ready=1 next cycle, previous result held.
  - rst_n low mid-CALC -> all outputs at reset values immediately.
  - A new op afterwards computes correctly.
- Width sweep, parallelism=8: MULH 0x80 x 0x7F -> 0xC0; DIV 0x80/0xFF -> 0x80; latency 10 edges.
